// File: rtl/mips_cpu_pkg.sv
// Shared fetch-redirect definitions: PC-select encoding, redirect FSM state
// encoding, the reset vector, and a helper that picks the post-latch state.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'd0,
    PC_HOLD  = 2'd1,
    PC_REDIR = 2'd2,
    PC_EXC   = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_JR   = 2'd1,
    ST_WAIT_SLOT = 2'd2,
    ST_REDIR     = 2'd3
  } redir_state_e;

  localparam logic [31:0] RESET_VECTOR  = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC_OFFSET = 32'd4;

  // A slot-1 branch already has its delay slot in the same packet, so it can
  // redirect next cycle; a slot-2 branch must wait for the slot packet.
  function automatic redir_state_e state_after_latch(input logic slot);
    return slot ? ST_WAIT_SLOT : ST_REDIR;
  endfunction

endpackage

// File: rtl/redirect_perf_cnt.sv
// Saturating performance counters for the fetch redirect controller:
// cycles spent redirecting (REDIR/EXC) and cycles spent holding fetch.
// Only instantiated when FETCH_REDIRECT_PERF_EN is defined.
module redirect_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_evt,
  input  logic        hold_evt,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_hold_cycles
);

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_redirects   <= '0;
      perf_hold_cycles <= '0;
    end else begin
      if (redirect_evt && (perf_redirects != '1))
        perf_redirects <= perf_redirects + 32'd1;
      if (hold_evt && (perf_hold_cycles != '1))
        perf_hold_cycles <= perf_hold_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: sequences branch/jr/exception redirects of the
// fetch PC, honouring the MIPS delay slot and pipeline stalls. Outputs are
// combinational so a redirect affects fetch in the same cycle it is decided.
// Optional feature: define FETCH_REDIRECT_PERF_EN to add performance counters.
module fetch_redirect_ctrl
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        br_req,
  input  logic        br_slot,
  input  logic [31:0] br_target,
  input  logic        jr_req,
  input  logic [31:0] jr_data,
  input  logic        jr_data_ok,
  input  logic        slot_fetched,
  input  logic        stall_hard,
  input  logic        stall_soft,
  output logic [1:0]  pc_sel,
  output logic [31:0] redirect_pc,
  output logic        flush_id,
`ifdef FETCH_REDIRECT_PERF_EN
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_hold_cycles,
`endif
  output logic        busy
);

  redir_state_e state, state_next;
  logic [31:0]  target, target_next;
  logic         slot, slot_next;
  pc_sel_e      sel;

  // State register plus the latched redirect target and issue slot.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      target <= RESET_VECTOR;
      slot   <= 1'b0;
    end else begin
      state  <= state_next;
      target <= target_next;
      slot   <= slot_next;
    end
  end

  // Next-state and output decode: exception > hard stall > pending redirect
  // > new request > soft stall.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    target_next = target;
    slot_next   = slot;
    sel         = PC_SEQ;
    redirect_pc = target;
    flush_id    = 1'b0;

    if (exc_req) begin
      sel         = PC_EXC;
      redirect_pc = exc_pc + EXC_PC_OFFSET;
      flush_id    = 1'b1;
      state_next  = ST_IDLE;
    end else if (stall_hard) begin
      sel = PC_HOLD;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // jr wins when both requests arrive together.
          if (jr_req) begin
            sel       = PC_HOLD;
            slot_next = br_slot;
            if (jr_data_ok) begin
              target_next = jr_data;
              state_next  = state_after_latch(br_slot);
            end else begin
              state_next = ST_WAIT_JR;
            end
          end else if (br_req) begin
            sel         = PC_HOLD;
            slot_next   = br_slot;
            target_next = br_target;
            state_next  = state_after_latch(br_slot);
          end else if (stall_soft) begin
            sel      = PC_HOLD;
            flush_id = 1'b1;
          end
        end
        ST_WAIT_JR: begin
          sel = PC_HOLD;
          if (jr_data_ok) begin
            target_next = jr_data;
            state_next  = state_after_latch(slot);
          end
        end
        ST_WAIT_SLOT: begin
          sel = PC_SEQ;
          if (slot_fetched) state_next = ST_REDIR;
        end
        ST_REDIR: begin
          sel        = PC_REDIR;
          flush_id   = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // While reset is held, fetch is frozen at the reset vector.
    if (!reset) begin
      sel         = PC_HOLD;
      redirect_pc = RESET_VECTOR;
      flush_id    = 1'b0;
    end
  end

  assign pc_sel = sel;
  assign busy   = (state != ST_IDLE);

`ifdef FETCH_REDIRECT_PERF_EN
  redirect_perf_cnt u_perf (
    .clk              (clk),
    .reset            (reset),
    .redirect_evt     ((sel == PC_REDIR) || (sel == PC_EXC)),
    .hold_evt         (sel == PC_HOLD),
    .perf_redirects   (perf_redirects),
    .perf_hold_cycles (perf_hold_cycles)
  );
`else
  // Performance counters not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl. Inputs change 1ns
// after each rising edge; combinational outputs are sampled 2ns later.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req, br_req, br_slot, jr_req, jr_data_ok;
  logic        slot_fetched, stall_hard, stall_soft;
  logic [31:0] exc_pc, br_target, jr_data;
  logic [1:0]  pc_sel;
  logic [31:0] redirect_pc;
  logic        flush_id, busy;
`ifdef FETCH_REDIRECT_PERF_EN
  logic [31:0] perf_redirects, perf_hold_cycles;
`endif

  int checks = 0;
  int passes = 0;

  localparam logic [1:0] SEQ = 2'd0, HOLD = 2'd1, REDIR = 2'd2, EXC = 2'd3;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .exc_req      (exc_req),
    .exc_pc       (exc_pc),
    .br_req       (br_req),
    .br_slot      (br_slot),
    .br_target    (br_target),
    .jr_req       (jr_req),
    .jr_data      (jr_data),
    .jr_data_ok   (jr_data_ok),
    .slot_fetched (slot_fetched),
    .stall_hard   (stall_hard),
    .stall_soft   (stall_soft),
    .pc_sel       (pc_sel),
    .redirect_pc  (redirect_pc),
    .flush_id     (flush_id),
`ifdef FETCH_REDIRECT_PERF_EN
    .perf_redirects   (perf_redirects),
    .perf_hold_cycles (perf_hold_cycles),
`endif
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    exc_req = 0; br_req = 0; br_slot = 0; jr_req = 0; jr_data_ok = 0;
    slot_fetched = 0; stall_hard = 0; stall_soft = 0;
    exc_pc = '0; br_target = '0; jr_data = '0;
  endtask

  // Advance to 1ns after the next rising edge and clear all requests.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic expect_out(input string tag, input logic [1:0] sel,
                            input logic fl, input logic bz);
    #2;
    check({tag, ".pc_sel"}, {30'd0, pc_sel}, {30'd0, sel});
    check({tag, ".flush"},  {31'd0, flush_id}, {31'd0, fl});
    check({tag, ".busy"},   {31'd0, busy}, {31'd0, bz});
  endtask

  task automatic expect_pc(input string tag, input logic [31:0] pc);
    check({tag, ".redirect_pc"}, redirect_pc, pc);
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    exc_req = 1; exc_pc = 32'h1234_0000;   // reset must override an exception
    expect_out("reset", HOLD, 0, 0);
    expect_pc("reset", 32'hBFC0_0000);

    // First cycle after release is IDLE/SEQ with the reset vector latched.
    next_cycle();
    reset = 1;
    expect_out("post_reset", SEQ, 0, 0);
    expect_pc("post_reset", 32'hBFC0_0000);

    // Slot-1 branch: HOLD, one REDIR cycle, then SEQ; request during REDIR ignored.
    next_cycle();
    br_req = 1; br_slot = 0; br_target = 32'h8000_0100;
    expect_out("br1_req", HOLD, 0, 0);
    next_cycle();
    br_req = 1; br_slot = 0; br_target = 32'hDEAD_BEEF;
    expect_out("br1_redir", REDIR, 1, 1);
    expect_pc("br1_redir", 32'h8000_0100);
    next_cycle();
    expect_out("br1_after", SEQ, 0, 0);

    // Slot-2 branch: HOLD, two SEQ cycles, REDIR, SEQ.
    next_cycle();
    br_req = 1; br_slot = 1; br_target = 32'h8000_0200;
    expect_out("br2_req", HOLD, 0, 0);
    next_cycle();
    expect_out("br2_wait0", SEQ, 0, 1);
    next_cycle();
    slot_fetched = 1;
    expect_out("br2_wait1", SEQ, 0, 1);
    next_cycle();
    expect_out("br2_redir", REDIR, 1, 1);
    expect_pc("br2_redir", 32'h8000_0200);
    next_cycle();
    expect_out("br2_after", SEQ, 0, 0);

    // jr without data for three cycles, data on the fourth, then REDIR.
    next_cycle();
    jr_req = 1; br_slot = 0;
    expect_out("jr_req", HOLD, 0, 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      expect_out("jr_wait", HOLD, 0, 1);
    end
    next_cycle();
    jr_data_ok = 1; jr_data = 32'h8000_2000;
    expect_out("jr_ok", HOLD, 0, 1);
    next_cycle();
    expect_out("jr_redir", REDIR, 1, 1);
    expect_pc("jr_redir", 32'h8000_2000);
    next_cycle();
    expect_out("jr_after", SEQ, 0, 0);

    // Exception during WAIT_SLOT: EXC same cycle, pending redirect dropped.
    next_cycle();
    br_req = 1; br_slot = 1; br_target = 32'h8000_0300;
    expect_out("exc_br", HOLD, 0, 0);
    next_cycle();
    exc_req = 1; exc_pc = 32'h8000_0180;
    expect_out("exc", EXC, 1, 1);
    expect_pc("exc", 32'h8000_0184);
    next_cycle();
    slot_fetched = 1;
    expect_out("exc_after0", SEQ, 0, 0);
    next_cycle();
    expect_out("exc_after1", SEQ, 0, 0);

    // Exception PC wraps modulo 2^32.
    next_cycle();
    exc_req = 1; exc_pc = 32'hFFFF_FFFE;
    expect_out("exc_wrap", EXC, 1, 0);
    expect_pc("exc_wrap", 32'h0000_0002);

    // Soft stall in IDLE: HOLD with flush.
    next_cycle();
    stall_soft = 1;
    expect_out("soft", HOLD, 1, 0);

    // br_req and jr_req together act as jr.
    next_cycle();
    br_req = 1; jr_req = 1; jr_data_ok = 1; br_slot = 0;
    br_target = 32'h8000_4000; jr_data = 32'h8000_3000;
    expect_out("both_req", HOLD, 0, 0);
    next_cycle();
    expect_out("both_redir", REDIR, 1, 1);
    expect_pc("both_redir", 32'h8000_3000);

    // Hard stall freezes WAIT_JR (jr data ignored), then a reset pulse.
    next_cycle();
    jr_req = 1; br_slot = 0;
    expect_out("hs_req", HOLD, 0, 0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      stall_hard = 1; jr_data_ok = 1; jr_data = 32'h8000_5000;
      expect_out("hs_frozen", HOLD, 0, 1);
    end
    next_cycle();
    reset = 0;
    expect_out("hs_reset", HOLD, 0, 0);
    expect_pc("hs_reset", 32'hBFC0_0000);
    next_cycle();
    reset = 1;
    expect_out("hs_release", SEQ, 0, 0);
    expect_pc("hs_release", 32'hBFC0_0000);
    next_cycle();
    expect_out("hs_idle", SEQ, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
